// File: rtl/pooling_sequencer_if.sv
// Scheduler-side job/result handshake plus PoolingUnit control bus for pooling_sequencer.
// Optional abort input present when POOLING_SEQ_ABORT_EN is defined.
interface pooling_sequencer_if #(
   parameter int unsigned depth = 4
);
   localparam int unsigned D = 1 << depth;
   localparam int unsigned W = depth + 1;

   logic             start;
   logic             in_ready;
   logic [W*D-1:0]   in_data;
   logic [3:0]       cfg_levels;
   logic [D-1:0]     cfg_lane_mask;
   logic             out_valid;
   logic             out_ready;
   logic [W*D-1:0]   out_data;
   logic             busy;
   logic [2:0]       stage_o;
   logic             pu_doPooling;
   logic [W*D-1:0]   pu_ip;
   logic [4*D-1:0]   pu_control;
   logic [W*D-1:0]   pu_op;
`ifdef POOLING_SEQ_ABORT_EN
   logic             abort;
`endif

   // sequencer side
   modport slave (
`ifdef POOLING_SEQ_ABORT_EN
      input  abort,
`endif
      input  start, in_data, cfg_levels, cfg_lane_mask, out_ready, pu_op,
      output in_ready, out_valid, out_data, busy, stage_o,
      output pu_doPooling, pu_ip, pu_control
   );

   // scheduler + PoolingUnit side
   modport master (
`ifdef POOLING_SEQ_ABORT_EN
      output abort,
`endif
      output start, in_data, cfg_levels, cfg_lane_mask, out_ready, pu_op,
      input  in_ready, out_valid, out_data, busy, stage_o,
      input  pu_doPooling, pu_ip, pu_control
   );
endinterface

// File: rtl/pooling_sequencer.sv
// Sequences one PoolingUnit through L reduction stages, feeding op back into ip.
// Define POOLING_SEQ_ABORT_EN to add an abort input that drops the running job.
module pooling_sequencer #(
   parameter int unsigned depth  = 4,
   parameter int unsigned PU_LAT = 2
) (
   input logic                 CLK,
   input logic                 RSTn,
   pooling_sequencer_if.slave  bus
);
   localparam int unsigned D  = 1 << depth;
   localparam int unsigned W  = depth + 1;
   localparam int unsigned NV = W * D;
   localparam int unsigned CW = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_POOL, S_DONE} state_t;

   state_t          r_state, w_state_nx;
   logic [NV-1:0]   r_work, w_work_nx, w_work_cap;
   logic [NV-1:0]   r_out_data, w_out_data_nx;
   logic [D-1:0]    r_mask, w_mask_nx;
   logic [2:0]      r_levels, w_levels_nx, w_clamp;
   logic [2:0]      r_stage, w_stage_nx;
   logic [CW-1:0]   r_cnt, w_cnt_nx;
   logic            r_in_ready, r_out_valid, r_busy, r_do_pool;
   logic [4*D-1:0]  r_control, w_control_nx;
   logic            w_abort;

`ifdef POOLING_SEQ_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   // Stage count clamped into 1..depth at accept
   always_comb begin
      w_clamp = 3'(bus.cfg_levels);
      if (bus.cfg_levels == 4'd0)
         w_clamp = 3'd1;
      else if (bus.cfg_levels > 4'(depth))
         w_clamp = 3'(depth);
   end

   // Active lanes take the unit result; masked lanes hold
   always_comb begin
      w_work_cap = r_work;
      for (int j = 0; j < int'(D); j++) begin
         if (r_mask[j])
            w_work_cap[W*j +: W] = bus.pu_op[W*j +: W];
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_work_nx     = r_work;
      w_out_data_nx = r_out_data;
      w_mask_nx     = r_mask;
      w_levels_nx   = r_levels;
      w_stage_nx    = r_stage;
      w_cnt_nx      = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_work_nx   = bus.in_data;
               w_mask_nx   = bus.cfg_lane_mask;
               w_levels_nx = w_clamp;
               w_stage_nx  = 3'd0;
               w_cnt_nx    = '0;
               w_state_nx  = S_POOL;
            end
         end
         S_POOL: begin
            if (r_cnt == CW'(PU_LAT - 1)) begin
               w_work_nx = w_work_cap;
               w_cnt_nx  = '0;
               if (r_stage == r_levels - 3'd1) begin
                  w_out_data_nx = w_work_cap;
                  w_state_nx    = S_DONE;
               end else begin
                  w_stage_nx = r_stage + 3'd1;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_stage_nx = 3'd0;
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      // Abort drops the job without publishing anything
      if (w_abort && (r_state != S_IDLE)) begin
         w_state_nx    = S_IDLE;
         w_work_nx     = r_work;
         w_out_data_nx = r_out_data;
         w_stage_nx    = 3'd0;
         w_cnt_nx      = '0;
      end
   end

   // Per-lane control for the upcoming cycle
   always_comb begin
      w_control_nx = '0;
      for (int j = 0; j < int'(D); j++) begin
         if ((w_state_nx == S_POOL) && w_mask_nx[j])
            w_control_nx[4*j +: 4] = {1'b1, w_stage_nx};
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state     <= S_IDLE;
         r_work      <= '0;
         r_out_data  <= '0;
         r_mask      <= '0;
         r_levels    <= 3'd1;
         r_stage     <= 3'd0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_do_pool   <= 1'b0;
         r_control   <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_work      <= w_work_nx;
         r_out_data  <= w_out_data_nx;
         r_mask      <= w_mask_nx;
         r_levels    <= w_levels_nx;
         r_stage     <= w_stage_nx;
         r_cnt       <= w_cnt_nx;
         r_in_ready  <= (w_state_nx == S_IDLE);
         r_out_valid <= (w_state_nx == S_DONE);
         r_busy      <= (w_state_nx != S_IDLE);
         r_do_pool   <= (w_state_nx == S_POOL);
         r_control   <= w_control_nx;
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_data     = r_out_data;
   assign bus.busy         = r_busy;
   assign bus.stage_o      = r_stage;
   assign bus.pu_doPooling = r_do_pool;
   assign bus.pu_ip        = r_work;
   assign bus.pu_control   = r_control;
endmodule

// File: tb/tb_pooling_sequencer.sv
// Randomized self-checking bench for pooling_sequencer against a lane-arithmetic reference model.
module tb_pooling_sequencer;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned D      = 1 << DEPTH;
   localparam int unsigned W      = DEPTH + 1;
   localparam int unsigned NV     = W * D;
   localparam int unsigned PU_LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   logic [NV-1:0] last_out = '0;
   logic [NV-1:0] stub_op;

   always #5 clk = ~clk;

   pooling_sequencer_if #(.depth(DEPTH)) bus();

   pooling_sequencer #(.depth(DEPTH), .PU_LAT(PU_LAT)) dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .bus  (bus)
   );

   // Stub PoolingUnit: op = ip + 1 on every lane
   always_comb begin
      stub_op = '0;
      for (int j = 0; j < int'(D); j++)
         stub_op[W*j +: W] = bus.pu_ip[W*j +: W] + W'(1);
   end
   assign bus.pu_op = stub_op;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp_l(input int lev);
      if (lev == 0) return 1;
      if (lev > int'(DEPTH)) return int'(DEPTH);
      return lev;
   endfunction

   // Expected vector after s applications of the +1 stub on active lanes
   function automatic logic [NV-1:0] model_vec(input logic [NV-1:0] in, input logic [D-1:0] mask, input int s);
      logic [NV-1:0] v;
      v = in;
      for (int j = 0; j < int'(D); j++)
         if (mask[j]) v[W*j +: W] = W'(int'(in[W*j +: W]) + s);
      return v;
   endfunction

   function automatic logic [4*D-1:0] ctrl_vec(input logic [D-1:0] mask, input int s);
      logic [4*D-1:0] c;
      c = '0;
      for (int j = 0; j < int'(D); j++)
         if (mask[j]) c[4*j +: 4] = {1'b1, 3'(s)};
      return c;
   endfunction

   function automatic logic [NV-1:0] rnd_vec();
      return NV'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic start_job(input logic [NV-1:0] in, input int lev, input logic [D-1:0] mask);
      bus.in_data       = in;
      bus.cfg_levels    = 4'(lev);
      bus.cfg_lane_mask = mask;
      bus.start         = 1'b1;
      @(posedge clk); #1;
      bus.start         = 1'b0;
   endtask

   // Called #1 after the accept edge; returns in DONE with the result checked
   task automatic check_job(input logic [NV-1:0] in, input int lev, input logic [D-1:0] mask, input int stall);
      int L;
      logic [NV-1:0] exp_out;
      L = clamp_l(lev);
      exp_out = model_vec(in, mask, L);
      for (int k = 0; k < L * int'(PU_LAT); k++) begin
         int s;
         s = k / int'(PU_LAT);
         chk("pool_busy",      128'(bus.busy), 128'(1));
         chk("pool_in_ready",  128'(bus.in_ready), 128'(0));
         chk("pool_out_valid", 128'(bus.out_valid), 128'(0));
         chk("pool_do",        128'(bus.pu_doPooling), 128'(1));
         chk("pool_stage",     128'(bus.stage_o), 128'(s));
         chk("pool_control",   128'(bus.pu_control), 128'(ctrl_vec(mask, s)));
         chk("pool_ip",        128'(bus.pu_ip), 128'(model_vec(in, mask, s)));
         bus.start         = 1'($urandom_range(0, 1));
         bus.in_data       = rnd_vec();
         bus.cfg_levels    = 4'($urandom_range(0, 15));
         bus.cfg_lane_mask = D'($urandom());
         @(posedge clk); #1;
      end
      chk("done_valid",   128'(bus.out_valid), 128'(1));
      chk("done_data",    128'(bus.out_data), 128'(exp_out));
      chk("done_do",      128'(bus.pu_doPooling), 128'(0));
      chk("done_control", 128'(bus.pu_control), 128'(0));
      chk("done_stage",   128'(bus.stage_o), 128'(L - 1));
      for (int i = 0; i < stall; i++) begin
         bus.start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("stall_valid", 128'(bus.out_valid), 128'(1));
         chk("stall_data",  128'(bus.out_data), 128'(exp_out));
      end
      bus.start = 1'b0;
      last_out  = exp_out;
   endtask

   task automatic release_job();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("idle_valid",    128'(bus.out_valid), 128'(0));
      chk("idle_in_ready", 128'(bus.in_ready), 128'(1));
      chk("idle_busy",     128'(bus.busy), 128'(0));
      chk("idle_stage",    128'(bus.stage_o), 128'(0));
      chk("idle_data",     128'(bus.out_data), 128'(last_out));
   endtask

   task automatic run_job(input logic [NV-1:0] in, input int lev, input logic [D-1:0] mask, input int stall);
      start_job(in, lev, mask);
      check_job(in, lev, mask, stall);
      release_job();
   endtask

   logic [NV-1:0] ramp;
   logic [NV-1:0] vin;
   logic [D-1:0]  vmask;
   int            vlev;

   initial begin
      bus.start = 1'b0;
      bus.in_data = '0;
      bus.cfg_levels = 4'd0;
      bus.cfg_lane_mask = '0;
      bus.out_ready = 1'b0;
`ifdef POOLING_SEQ_ABORT_EN
      bus.abort = 1'b0;
`endif
      for (int j = 0; j < int'(D); j++) ramp[W*j +: W] = W'(j);

      #12;
      chk("rst_valid",   128'(bus.out_valid), 128'(0));
      chk("rst_busy",    128'(bus.busy), 128'(0));
      chk("rst_data",    128'(bus.out_data), 128'(0));
      chk("rst_ip",      128'(bus.pu_ip), 128'(0));
      chk("rst_control", 128'(bus.pu_control), 128'(0));
      chk("rst_do",      128'(bus.pu_doPooling), 128'(0));
      chk("rst_stage",   128'(bus.stage_o), 128'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));

      run_job(ramp, 1, 16'hFFFF, 0);
      run_job(ramp, 3, 16'hFFFF, 0);
      run_job(ramp, 2, 16'h00FF, 0);
      run_job(rnd_vec(), 0, 16'hFFFF, 5);
      run_job(rnd_vec(), 9, D'($urandom()), 5);
      run_job(rnd_vec(), 3, 16'h0000, 1);

      // start held high across DONE->IDLE is taken on the first IDLE edge
      vin = rnd_vec();
      start_job(ramp, 2, 16'hF0F0);
      check_job(ramp, 2, 16'hF0F0, 2);
      bus.in_data = vin;
      bus.cfg_levels = 4'd2;
      bus.cfg_lane_mask = 16'h3C3C;
      bus.start = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("chain_in_ready", 128'(bus.in_ready), 128'(1));
      chk("chain_valid",    128'(bus.out_valid), 128'(0));
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_job(vin, 2, 16'h3C3C, 0);
      release_job();

      for (int n = 0; n < 20; n++) begin
         vin = rnd_vec();
         vlev = int'($urandom_range(0, 15));
         vmask = D'($urandom());
         run_job(vin, vlev, vmask, int'($urandom_range(0, 3)));
      end

`ifdef POOLING_SEQ_ABORT_EN
      vin = rnd_vec();
      start_job(vin, 3, 16'hFFFF);
      for (int k = 0; k < int'(PU_LAT); k++) begin
         @(posedge clk); #1;
      end
      chk("abort_stage", 128'(bus.stage_o), 128'(1));
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
      chk("abort_busy",     128'(bus.busy), 128'(0));
      chk("abort_valid",    128'(bus.out_valid), 128'(0));
      chk("abort_do",       128'(bus.pu_doPooling), 128'(0));
      chk("abort_control",  128'(bus.pu_control), 128'(0));
      chk("abort_data",     128'(bus.out_data), 128'(last_out));
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_idle_ready", 128'(bus.in_ready), 128'(1));
      chk("abort_idle_data",  128'(bus.out_data), 128'(last_out));
      run_job(rnd_vec(), 2, 16'hFFFF, 0);
`endif

      // Asynchronous reset in the middle of a job
      vin = rnd_vec();
      start_job(vin, 4, 16'hFFFF);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid",   128'(bus.out_valid), 128'(0));
      chk("mid_rst_busy",    128'(bus.busy), 128'(0));
      chk("mid_rst_control", 128'(bus.pu_control), 128'(0));
      chk("mid_rst_do",      128'(bus.pu_doPooling), 128'(0));
      chk("mid_rst_ip",      128'(bus.pu_ip), 128'(0));
      chk("mid_rst_data",    128'(bus.out_data), 128'(0));
      @(negedge clk) rst_n = 1'b1;
      last_out = '0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
      run_job(ramp, 2, 16'hFFFF, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pooling_sequencer.md
Name: pooling_sequencer

Overview:
- Controller that sequences one PoolingUnit through a multi-stage reduction job.
- Accepts a job (input vector, stage count, lane mask) through a valid/ready-style start handshake.
- Drives the unit's doPooling, ip and per-lane control, and feeds the unit's op back into its ip between stages.
- Returns the reduced vector through an out_valid/out_ready handshake. Sits between the layer scheduler and the PoolingUnit.

Parameters:
- depth, 4, log2 of lane count.
- D, 1<<depth, number of lanes.
- W, depth+1, bits per lane.
- PU_LAT, 2, cycles each stage's control is held; the unit's op is valid on the last of these cycles (must be >= 1).

Ports:
- CLK  in  1  clock; rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only when in_ready=1.
- in_ready  out  1  high in IDLE.
- in_data  in  W*D  input vector; lane j = in_data[W*(j+1)-1 -:W].
- cfg_levels  in  4  number of stages; sampled with start.
- cfg_lane_mask  in  D  lane j participates when bit j=1; sampled with start.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  W*D  result vector.
- busy  out  1  state != IDLE.
- stage_o  out  3  current stage index.
- pu_doPooling  out  1  to PoolingUnit.doPooling.
- pu_ip  out  W*D  to PoolingUnit.ip; driven from the work register.
- pu_control  out  4*D  to PoolingUnit.control; lane j = pu_control[4*(j+1)-1 -:4].
- pu_op  in  W*D  from PoolingUnit.op.

Behaviour:
- Reset (RSTn=0, immediate):
  - State IDLE.
  - out_valid=0, out_data=0, busy=0, stage_o=0, pu_doPooling=0, pu_control=0.
  - Work register = 0, so pu_ip=0.
  - in_ready=1 once RSTn is released.
  - Reset mid-job abandons the job entirely; no partial result is kept.
- Config clamp at accept:
  - L = 1 if cfg_levels==0.
  - L = depth if cfg_levels>depth.
  - Otherwise L = cfg_levels.
- States: IDLE, POOL, DONE.
- IDLE:
  - in_ready=1.
  - On start=1 at an edge: work reg <= in_data, mask <= cfg_lane_mask, L latched, stage <= 0, cycle counter <= 0, go to POOL.
- POOL:
  - pu_doPooling=1.
  - Active lanes: pu_control = {1'b1, stage[2:0]}. Masked lanes: 4'b0000.
  - Counter increments each cycle.
  - When counter == PU_LAT-1: active lanes of the work reg <= pu_op lanes; masked lanes keep their value. Counter is cleared.
  - If stage == L-1: out_data <= next work reg value, go to DONE. Otherwise stage+1.
- Latency: start sampled at edge t0 gives out_valid=1 after edge t0 + L*PU_LAT.
- DONE:
  - out_valid=1, pu_doPooling=0, pu_control=0.
  - out_data is stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - The next start is accepted no earlier than the edge after returning to IDLE.
- start while busy is ignored and not queued.
- start held high through DONE→IDLE is accepted on the first IDLE edge.
- Mask all-zero: the job still runs L*PU_LAT cycles with all pu_control=0; out_data == in_data.
- stage_o = stage register; 0 in IDLE.
- out_data keeps its last result in IDLE until overwritten or reset.

Optional Feature:
- Macro POOLING_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in POOL or DONE: go to IDLE, out_valid<=0, pu_doPooling<=0, pu_control<=0. out_data is not updated by the aborted job.
  - abort in IDLE has no effect.
  - abort has priority over start and over a stage-completion capture on the same edge.
- When undefined: no abort port; a job can only end via the out_ready handshake or reset.

Test Plan:
1. Reset: assert RSTn=0 mid-POOL with random state → out_valid=0, busy=0, pu_control=0, pu_doPooling=0 immediately, without waiting for a clock edge.
2. Single stage, PU_LAT=2, cfg_levels=1, mask=16'hFFFF, in_data lane j=j, stub unit op = ip+1:
   - pu_control=16{4'b1000} for 2 cycles.
   - out_valid rises after edge t0+2.
   - out_data lane j = j+1.
3. Three stages, same stub, cfg_levels=3:
   - pu_control steps 4'b1000 → 4'b1001 → 4'b1010, each held 2 cycles.
   - pu_ip shows feedback.
   - Final lane j = j+3; out_valid after edge t0+6.
4. Mask 16'h00FF, cfg_levels=2, same stub:
   - Lanes 8-15 see control 4'b0000.
   - Output lanes 0-7 = j+2; lanes 8-15 = j.
5. Backpressure and clamp:
   - out_ready=0 for 5 cycles with cfg_levels=0 (runs 1 stage) then cfg_levels=9 (runs 4 stages): out_data stable while held.
   - start pulses during busy are ignored.
   - With out_ready=1 and start held high, the next job is accepted on the first IDLE edge.
6. POOLING_SEQ_ABORT_EN: abort at stage 1 of an L=3 job → IDLE next edge, out_data unchanged from the previous job, in_ready=1.
